inv_shot_sched: RTL and testbench
=================================

# inv_shot_sched

Round-robin scheduler that shares the single enemy-bullet slot among the 24 invaders of the current wave. Sits between the game controller (lvl_start, level, inv_en) and the enemy-bullet unit. It paces shots by a level-dependent frame cooldown, then picks the next live invader in rotation and hands its index to the bullet unit with a req/ack handshake.

## Interface
- N_INV, 24: number of invader slots (width of inv_en).
- IDX_W, 5: width of fire_idx.
- CD_W, 6: width of the cooldown frame counter.

Ports:
- s_clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- lvl_start  in  1  high while a level is in play; low forces IDLE.
- level  in  3  current level, 1..5; 0 or 6..7 means no firing.
- inv_en  in  N_INV  live-invader mask; bit i high means invader i may fire.
- frame_tick  in  1  one-cycle pulse per video frame.
- fire_ack  in  1  bullet unit has latched fire_idx (one-cycle pulse).
- shot_active  in  1  enemy bullet in flight.
- fire_req  out  1  request to launch from invader fire_idx.
- fire_idx  out  IDX_W  index of the selected invader, 0..N_INV-1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, COOLDOWN, SEARCH, FIRE, WAIT.
- Reset (async, rst=0) values:
  - State: IDLE.
  - fire_req: 0.
  - fire_idx: 0.
  - Rotation pointer: 0.
  - Cooldown counter: 0.
  - busy: 0.
- IDLE:
  - lvl_start=1 and level in 1..5: load cooldown with CD(level), go to COOLDOWN.
  - CD(level) = 56 - 8*level, i.e. 48/40/32/24/16 frames.
  - Otherwise stay in IDLE.
- COOLDOWN:
  - Decrement on each frame_tick.
  - When the counter is 0 at a frame_tick, go to SEARCH.
  - Frames with no tick hold the count.
- SEARCH:
  - Examine one index per cycle, starting at the pointer. Wrap at N_INV-1 to 0.
  - First index with inv_en[i]=1: set fire_idx=i, set pointer=i+1 (wrapped), go to FIRE.
  - After N_INV consecutive misses: reload CD(level), go to COOLDOWN. Pointer is unchanged.
- FIRE:
  - fire_req=1 with fire_idx stable until fire_ack.
  - fire_ack: fire_req=0, go to WAIT.
  - inv_en[fire_idx] drops without ack in the same cycle: fire_req=0, go to SEARCH from the pointer. The pointer already equals fire_idx+1.
  - Ack and drop in the same cycle: ack wins.
- WAIT:
  - Stay while shot_active=1.
  - On shot_active=0: reload CD(level), go to COOLDOWN.
  - WAIT ignores shot_active for its first cycle, because the bullet unit raises shot_active one cycle after ack.
- Global abort: lvl_start=0 or level out of range in any state → IDLE on the next edge. This clears fire_req and the counter; the pointer resets to 0.
- The level is sampled when the cooldown is loaded. A change of level mid-cooldown takes effect at the next load.

## Timing
- frame_tick at count 0 → SEARCH on the next edge.
- First live index found after k misses (k = 0..N_INV-1): fire_req rises k+1 cycles after entering SEARCH.
- fire_req is registered and falls on the edge that samples fire_ack.
- Maximum SEARCH length: N_INV cycles.
- busy is combinational from the state register.
- frame_tick arriving during SEARCH, FIRE or WAIT is ignored.
- fire_ack arriving outside FIRE is ignored.

## Structure
- Shared package inv_pkg:
  - State enum constants.
  - N_INV, IDX_W.
  - Function cd_frames(level) returning the CD_W-bit cooldown.
  - The same function is reused by any future speed tables.
- Sub-module rr_pointer: holds the wrapping pointer with advance/load/clear, reused by the planned invader-column arbiter.
- The FSM, cooldown counter and handshake stay in the top module.

## Test plan
- Level-1 cooldown: reset, then lvl_start=1, level=1, inv_en=24'h00aa55, steady frame_tick. Required:
  - Enter COOLDOWN.
  - The 49th tick moves to SEARCH.
  - fire_req with fire_idx=0.
  - Ack, then shot_active low for one pulse → second fire_idx=2.
- Rotation wrap: inv_en=24'h800001, with pointer state from the previous grant at 23. Required: next grant is idx 0, the following one 23.
- Empty mask: inv_en=0 in SEARCH. Required:
  - Exactly 24 cycles in SEARCH.
  - Return to COOLDOWN with 48 frames (level 1).
  - No fire_req.
- Target killed before ack: in FIRE with idx 5, clear inv_en[5] without ack (mask 24'h000060). Required:
  - fire_req drops next cycle.
  - Re-grant idx 6.
  - Ack and bit-clear in the same cycle → WAIT.
- Abort: drop lvl_start while in FIRE and while in COOLDOWN. Required:
  - IDLE on the next edge.
  - fire_req=0, busy=0.
  - Async rst mid-SEARCH resets all outputs immediately.
- Level range: level=5 gives a 16-frame cooldown. level=0 or 6 keeps the block in IDLE.

Source files
------------

// File: rtl/inv_pkg.sv
// Shared definitions for the invader shot scheduler: sizes, state encoding
// and the level-to-cooldown table.
package inv_pkg;

    localparam int N_INV = 24;
    localparam int IDX_W = 5;
    localparam int CD_W  = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COOLDOWN,
        ST_SEARCH,
        ST_FIRE,
        ST_WAIT
    } state_e;

    // Levels 1..5 are playable; anything else means "no firing".
    function automatic logic level_ok(input logic [2:0] level);
        return (level >= 3'd1) && (level <= 3'd5);
    endfunction

    // Frames between shots: 56 - 8*level (48/40/32/24/16).
    function automatic logic [CD_W-1:0] cd_frames(input logic [2:0] level);
        if (level_ok(level)) begin
            return CD_W'(56) - CD_W'({level, 3'b000});
        end
        return '0;
    endfunction

endpackage

// File: rtl/inv_shot_sched_rr_pointer.sv
// Wrapping round-robin pointer over N slots with clear/load/advance.
// Priority: clear, then load, then advance.
module rr_pointer
    import inv_pkg::*;
#(
    parameter int N = N_INV,
    parameter int W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         advance_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value, wrapping from N-1 back to 0 on advance.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (load_i) begin
            ptr_d = load_val_i;
        end else if (advance_i) begin
            ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/inv_shot_sched.sv
// Round-robin enemy shot scheduler: waits a level-dependent number of
// frames, scans the live-invader mask from the rotation pointer and offers
// the chosen invader to the bullet unit.
//
// Handshake fire_req/fire_ack: fire_req acts as valid and fire_ack as a
// one-cycle accept. While fire_req is high, fire_idx is held stable; the
// transfer happens on the edge that samples fire_ack high, and fire_req is
// low from that edge on. fire_req may also be withdrawn without an accept
// if the offered invader dies first; an ack in that same cycle still wins.
module inv_shot_sched
    import inv_pkg::*;
(
    input  logic             s_clk,
    input  logic             rst,
    input  logic             lvl_start,
    input  logic [2:0]       level,
    input  logic [N_INV-1:0] inv_en,
    input  logic             frame_tick,
    input  logic             fire_ack,
    input  logic             shot_active,
    output logic             fire_req,
    output logic [IDX_W-1:0] fire_idx,
    output logic             busy,
    output state_e           dbg_state_o
);

    state_e           state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [IDX_W-1:0] miss_q, miss_d;
    logic             wait_first_q, wait_first_d;
    logic             fire_req_q, fire_req_d;
    logic [IDX_W-1:0] fire_idx_q, fire_idx_d;

    logic [IDX_W-1:0] ptr;
    logic             ptr_clear;
    logic             ptr_load;
    logic [IDX_W-1:0] ptr_load_val;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    logic             run_ok;

    assign run_ok = lvl_start && level_ok(level);

    rr_pointer #(.N(N_INV), .W(IDX_W)) u_ptr (
        .clk        (s_clk),
        .rst_n      (rst),
        .clear_i    (ptr_clear),
        .load_i     (ptr_load),
        .load_val_i (ptr_load_val),
        .advance_i  (1'b0),
        .ptr_o      (ptr)
    );

    // Index under examination this SEARCH cycle: pointer + misses, mod N_INV.
    always_comb begin
        scan_sum = {1'b0, ptr} + {1'b0, miss_q};
        scan_idx = scan_sum[IDX_W-1:0];
        if (scan_sum >= (IDX_W + 1)'(N_INV)) begin
            scan_idx = scan_sum[IDX_W-1:0] - IDX_W'(N_INV);
        end
    end

    // Next-state logic for the FSM, cooldown counter, scan counter and grant.
    always_comb begin
        state_d      = state_q;
        cd_d         = cd_q;
        miss_d       = miss_q;
        wait_first_d = 1'b0;
        fire_idx_d   = fire_idx_q;
        ptr_clear    = 1'b0;
        ptr_load     = 1'b0;
        ptr_load_val = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);

        if (!run_ok) begin
            state_d   = ST_IDLE;
            cd_d      = '0;
            miss_d    = '0;
            ptr_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cd_d    = cd_frames(level);
                    state_d = ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (cd_q == '0) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                        end else begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end
                end
                ST_SEARCH: begin
                    if (inv_en[scan_idx]) begin
                        fire_idx_d = scan_idx;
                        ptr_load   = 1'b1;
                        miss_d     = '0;
                        state_d    = ST_FIRE;
                    end else if (miss_q == LAST_IDX) begin
                        // Whole ring empty: back off, pointer untouched.
                        cd_d    = cd_frames(level);
                        miss_d  = '0;
                        state_d = ST_COOLDOWN;
                    end else begin
                        miss_d = miss_q + IDX_W'(1);
                    end
                end
                ST_FIRE: begin
                    if (fire_ack) begin
                        wait_first_d = 1'b1;
                        state_d      = ST_WAIT;
                    end else if (!inv_en[fire_idx_q]) begin
                        // Target died; pointer already sits just past it.
                        miss_d  = '0;
                        state_d = ST_SEARCH;
                    end
                end
                ST_WAIT: begin
                    // shot_active lags the ack by one cycle, so skip cycle one.
                    if (!wait_first_q && !shot_active) begin
                        cd_d    = cd_frames(level);
                        state_d = ST_COOLDOWN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        fire_req_d = (state_d == ST_FIRE);
    end

    // State and datapath registers.
    always_ff @(posedge s_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cd_q         <= '0;
            miss_q       <= '0;
            wait_first_q <= 1'b0;
            fire_req_q   <= 1'b0;
            fire_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            cd_q         <= cd_d;
            miss_q       <= miss_d;
            wait_first_q <= wait_first_d;
            fire_req_q   <= fire_req_d;
            fire_idx_q   <= fire_idx_d;
        end
    end

    assign fire_req    = fire_req_q;
    assign fire_idx    = fire_idx_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_shot_sched.sv
// Bench for inv_shot_sched: scenario tasks with a behavioural model of the
// rotation (ring scan over the mask), cooldown length and bullet-wait rules.
module tb_inv_shot_sched;
    import inv_pkg::*;

    logic             s_clk = 1'b0;
    logic             rst;
    logic             lvl_start;
    logic [2:0]       level;
    logic [N_INV-1:0] inv_en;
    logic             frame_tick;
    logic             fire_ack;
    logic             shot_active;
    logic             fire_req;
    logic [IDX_W-1:0] fire_idx;
    logic             busy;
    state_e           dbg_state;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int ptr_m = 0;
    int cd_m = 0;
    int last_grant_m = 0;
    bit last_hit = 1'b0;
    logic [IDX_W-1:0] exp_q[$];

    // Clock and watchdog
    always #5 s_clk = ~s_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    inv_shot_sched dut (
        .s_clk       (s_clk),
        .rst         (rst),
        .lvl_start   (lvl_start),
        .level       (level),
        .inv_en      (inv_en),
        .frame_tick  (frame_tick),
        .fire_ack    (fire_ack),
        .shot_active (shot_active),
        .fire_req    (fire_req),
        .fire_idx    (fire_idx),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Model helpers
    function automatic int cd_of(input int lvl);
        return 56 - 8 * lvl;
    endfunction

    function automatic int find_live(input logic [N_INV-1:0] mask, input int start, output int k);
        for (int i = 0; i < N_INV; i++) begin
            int idx;
            idx = (start + i) % N_INV;
            if (mask[idx]) begin
                k = i;
                return idx;
            end
        end
        k = N_INV;
        return -1;
    endfunction

    // Driver / phase tasks (all entered and left on a negedge)
    task automatic start_level(input int lvl, input string name);
        lvl_start = 1'b1;
        level     = 3'(lvl);
        @(negedge s_clk);
        cd_m = cd_of(lvl);
        checks++;
        if (dbg_state !== ST_COOLDOWN || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start: state=%s busy=%b, required COOLDOWN busy=1", name, dbg_state.name(), busy);
        end
    endtask

    task automatic abort(input string name);
        lvl_start = 1'b0;
        @(negedge s_clk);
        ptr_m = 0;
        checks++;
        if (dbg_state !== ST_IDLE || fire_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: state=%s fire_req=%b busy=%b, required IDLE 0 0", name, dbg_state.name(), fire_req, busy);
        end
    endtask

    task automatic cooldown_phase(input int exp_ticks, input bit rnd, input int chg_lvl, input string name);
        int ticks;
        int n;
        ticks = 0;
        n = 0;
        while (dbg_state == ST_COOLDOWN && n < 400) begin
            frame_tick = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (frame_tick) ticks++;
            if (chg_lvl != 0 && n == 3) level = 3'(chg_lvl);
            n++;
            @(negedge s_clk);
        end
        frame_tick = 1'b0;
        checks++;
        if (dbg_state !== ST_SEARCH || ticks != exp_ticks) begin
            errors++;
            $display("FAIL %s cooldown: ticks=%0d state=%s, required ticks=%0d state=SEARCH", name, ticks, dbg_state.name(), exp_ticks);
        end
    endtask

    task automatic search_phase(input bit noise, input string name);
        int k;
        int idx;
        int lat;
        int seen_req;
        logic [IDX_W-1:0] e;
        idx = find_live(inv_en, ptr_m, k);
        lat = 0;
        seen_req = 0;
        if (idx >= 0) begin
            exp_q.push_back(IDX_W'(idx));
            while (fire_req !== 1'b1 && lat < 2 * N_INV) begin
                fire_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                lat++;
                @(negedge s_clk);
            end
            fire_ack   = 1'b0;
            frame_tick = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (lat != k + 1) begin
                errors++;
                $display("FAIL %s grant latency: got %0d cycles, required %0d", name, lat, k + 1);
            end
            checks++;
            if (fire_req !== 1'b1 || fire_idx !== e) begin
                errors++;
                $display("FAIL %s grant idx: fire_req=%b fire_idx=%0d, required 1 and %0d", name, fire_req, fire_idx, e);
            end
            ptr_m = (idx + 1) % N_INV;
            last_grant_m = idx;
            last_hit = 1'b1;
        end else begin
            while (dbg_state == ST_SEARCH && lat < 2 * N_INV) begin
                if (fire_req !== 1'b0) seen_req++;
                fire_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                lat++;
                @(negedge s_clk);
            end
            fire_ack   = 1'b0;
            frame_tick = 1'b0;
            if (fire_req !== 1'b0) seen_req++;
            cd_m = cd_of(int'(level));
            last_hit = 1'b0;
            checks++;
            if (lat != N_INV || seen_req != 0 || dbg_state !== ST_COOLDOWN) begin
                errors++;
                $display("FAIL %s empty search: cycles=%0d reqs=%0d state=%s, required %0d 0 COOLDOWN", name, lat, seen_req, dbg_state.name(), N_INV);
            end
        end
    endtask

    task automatic fire_phase(input int hold, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            @(negedge s_clk);
            if (fire_req !== 1'b1 || fire_idx !== IDX_W'(last_grant_m)) bad++;
        end
        frame_tick = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s hold: %0d unstable cycles, fire_idx=%0d, required stable req at %0d", name, bad, fire_idx, last_grant_m);
        end
        fire_ack = 1'b1;
        @(negedge s_clk);
        fire_ack = 1'b0;
        checks++;
        if (fire_req !== 1'b0 || dbg_state !== ST_WAIT) begin
            errors++;
            $display("FAIL %s ack: fire_req=%b state=%s, required 0 WAIT", name, fire_req, dbg_state.name());
        end
    endtask

    task automatic wait_phase(input int l, input string name);
        int n;
        int exp_len;
        n = 0;
        exp_len = ((l < 1) ? 1 : l) + 1;
        while (dbg_state == ST_WAIT && n < 200) begin
            shot_active = (n < l);
            n++;
            @(negedge s_clk);
        end
        shot_active = 1'b0;
        cd_m = cd_of(int'(level));
        checks++;
        if (n != exp_len || dbg_state !== ST_COOLDOWN || fire_req !== 1'b0) begin
            errors++;
            $display("FAIL %s wait: cycles=%0d state=%s, required %0d then COOLDOWN", name, n, dbg_state.name(), exp_len);
        end
    endtask

    task automatic round(input logic [N_INV-1:0] mask, input int hold, input int l,
                         input bit rnd, input int chg_lvl, input int nxt_lvl, input string name);
        inv_en = mask;
        cooldown_phase(cd_m + 1, rnd, chg_lvl, name);
        search_phase(rnd, name);
        if (last_hit) begin
            fire_phase(hold, name);
            if (nxt_lvl != 0) level = 3'(nxt_lvl);
            wait_phase(l, name);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b0; lvl_start = 1'b0; level = 3'd0; inv_en = '0;
        frame_tick = 1'b0; fire_ack = 1'b0; shot_active = 1'b0;
        repeat (3) @(negedge s_clk);
        checks++;
        if (fire_req !== 1'b0 || fire_idx !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: fire_req=%b fire_idx=%0d busy=%b, required 0 0 0", fire_req, fire_idx, busy);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset state: %s, required IDLE", dbg_state.name());
        end
        rst = 1'b1;
        @(negedge s_clk);
        ptr_m = 0;
    endtask

    task automatic test_level1();
        inv_en = 24'h00aa55;
        start_level(1, "l1");
        cooldown_phase(49, 1'b0, 0, "l1_first");
        search_phase(1'b0, "l1_first");
        fire_phase(2, "l1_first");
        wait_phase(1, "l1_first");
        round(24'h00aa55, 1, 0, 1'b0, 0, 0, "l1_second");
        checks++;
        if (last_grant_m != 2) begin
            errors++;
            $display("FAIL l1_second model idx: %0d, required 2", last_grant_m);
        end
    endtask

    task automatic test_wrap();
        round(24'h800000, 0, 2, 1'b1, 0, 0, "wrap_23");
        round(24'h800001, 1, 1, 1'b1, 0, 0, "wrap_0");
        round(24'h800001, 0, 0, 1'b1, 0, 0, "wrap_23b");
    endtask

    task automatic test_empty();
        round('0, 0, 0, 1'b1, 0, 0, "empty");
        round(24'h00aa55, 0, 0, 1'b1, 0, 0, "after_empty");
    endtask

    task automatic test_kill();
        abort("kill_pre");
        inv_en = 24'h000060;
        start_level(5, "kill");
        cooldown_phase(cd_m + 1, 1'b0, 0, "kill");
        search_phase(1'b0, "kill_5");
        inv_en = 24'h000040;
        @(negedge s_clk);
        checks++;
        if (fire_req !== 1'b0 || dbg_state !== ST_SEARCH) begin
            errors++;
            $display("FAIL kill drop: fire_req=%b state=%s, required 0 SEARCH", fire_req, dbg_state.name());
        end
        search_phase(1'b0, "kill_6");
        fire_ack = 1'b1;
        inv_en = '0;
        @(negedge s_clk);
        fire_ack = 1'b0;
        checks++;
        if (fire_req !== 1'b0 || dbg_state !== ST_WAIT) begin
            errors++;
            $display("FAIL kill ack_and_drop: fire_req=%b state=%s, required 0 WAIT", fire_req, dbg_state.name());
        end
        wait_phase(0, "kill");
    endtask

    task automatic test_abort();
        repeat (3) begin
            frame_tick = 1'b1;
            @(negedge s_clk);
        end
        frame_tick = 1'b0;
        abort("abort_cd");
        inv_en = 24'h000110;
        start_level(5, "abort_restart");
        cooldown_phase(cd_m + 1, 1'b0, 0, "abort_restart");
        search_phase(1'b0, "abort_restart");
        abort("abort_fire");
        inv_en = '0;
        start_level(5, "async");
        cooldown_phase(cd_m + 1, 1'b0, 0, "async");
        repeat (3) @(negedge s_clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (fire_req !== 1'b0 || fire_idx !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async reset: fire_req=%b fire_idx=%0d busy=%b, required 0 0 0", fire_req, fire_idx, busy);
        end
        @(negedge s_clk);
        lvl_start = 1'b0;
        rst = 1'b1;
        ptr_m = 0;
        @(negedge s_clk);
    endtask

    task automatic test_level_range();
        int bad_lv[3] = '{0, 6, 7};
        int bad;
        for (int j = 0; j < 3; j++) begin
            lvl_start = 1'b1;
            level = 3'(bad_lv[j]);
            bad = 0;
            repeat (4) begin
                frame_tick = 1'b1;
                @(negedge s_clk);
                if (busy !== 1'b0 || dbg_state !== ST_IDLE) bad++;
            end
            frame_tick = 1'b0;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL level_range %0d: busy/state left IDLE in %0d cycles, required 0", bad_lv[j], bad);
            end
        end
        lvl_start = 1'b0;
        @(negedge s_clk);
        inv_en = 24'h0f0000;
        start_level(5, "lvl5");
        cooldown_phase(17, 1'b1, 0, "lvl5");
        search_phase(1'b0, "lvl5");
        fire_phase(0, "lvl5");
        wait_phase(3, "lvl5");
    endtask

    task automatic test_random();
        logic [N_INV-1:0] m;
        int chg;
        int nxt;
        abort("rnd_pre");
        start_level($urandom_range(1, 5), "rnd_start");
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 5))
                0: m = '0;
                1: m = N_INV'(1) << $urandom_range(0, N_INV - 1);
                default: m = N_INV'($urandom & $urandom);
            endcase
            chg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            nxt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            round(m, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, chg, nxt,
                  $sformatf("rnd%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_level1();
        test_wrap();
        test_empty();
        test_kill();
        test_abort();
        test_level_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
